// File: rtl/trace_pkg.sv
// trace_pkg: state encoding and default sizing shared by the trace buffer files.
package trace_pkg;

   // Capture/readout phases of the buffer
   typedef logic [1:0] state_t;

   localparam state_t ST_FILL = 2'd0;
   localparam state_t ST_READ = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   localparam int DEF_SAMPLE_PACKET_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH          = 10;

endpackage

// File: rtl/trace_ram.sv
// trace_ram: simple dual-port storage, one write port and a registered read
// port with one cycle of latency. Contents are intentionally never reset.
module trace_ram
   import trace_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_SAMPLE_PACKET_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_q
);

   logic [DATA_WIDTH-1:0] mem_r [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rd_q_r;

   // Write port: store one word per enabled cycle
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Read port: registered output, updated only when a read is issued
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_q_r <= mem_r[rd_addr];
      end
   end

   assign rd_q = rd_q_r;

endmodule

// File: rtl/trace_buffer.sv
// trace_buffer: capture buffer that fills with sample packets (circular or
// stop-at-full), then freezes and plays the trace back oldest-first.
// Optional feature: define TRACE_BUFFER_PARITY_EN to store an even-parity bit
// per word and flag mismatches on readout through rd_parity_err.
module trace_buffer
   import trace_pkg::*;
#(
   parameter int SAMPLE_PACKET_WIDTH = DEF_SAMPLE_PACKET_WIDTH,
   parameter int ADDR_WIDTH          = DEF_ADDR_WIDTH
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           clear,
   input  logic                           wrap_en,
   input  logic [SAMPLE_PACKET_WIDTH-1:0] samplePacket,
   input  logic                           write_enable,
   input  logic [31:0]                    sample_number,
   output logic                           pageFull,
   output logic                           overflow,
   output logic [ADDR_WIDTH:0]            trace_size,
   output logic [31:0]                    last_sample_number,
   input  logic                           rd_start,
   input  logic                           rd_next,
   output logic [SAMPLE_PACKET_WIDTH-1:0] rd_data,
   output logic                           rd_valid,
`ifdef TRACE_BUFFER_PARITY_EN
   output logic                           rd_parity_err,
`endif
   output logic                           rd_done
);

`ifdef TRACE_BUFFER_PARITY_EN
   localparam int RAM_WIDTH = SAMPLE_PACKET_WIDTH + 1;
`else
   localparam int RAM_WIDTH = SAMPLE_PACKET_WIDTH;
`endif
   localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

   state_t                         state_r;
   state_t                         state_nxt_s;
   logic [ADDR_WIDTH-1:0]          wr_ptr_r;
   logic [ADDR_WIDTH-1:0]          wr_ptr_nxt_s;
   logic [ADDR_WIDTH-1:0]          rd_ptr_r;
   logic [ADDR_WIDTH:0]            count_r;
   logic [ADDR_WIDTH:0]            count_nxt_s;
   logic [ADDR_WIDTH:0]            rd_cnt_r;
   logic                           overflow_r;
   logic                           inflight_r;
   logic                           rd_valid_r;
   logic                           rd_done_r;
   logic [31:0]                    last_sn_r;
   logic [SAMPLE_PACKET_WIDTH-1:0] rd_data_r;
   logic [RAM_WIDTH-1:0]           ram_wdata_s;
   logic [RAM_WIDTH-1:0]           ram_q_s;

   logic full_s;
   logic wr_try_s;
   logic wr_accept_s;
   logic wr_drop_s;
   logic start_s;
   logic rd_issue_s;
   logic rd_finish_s;

   assign full_s      = (count_r == FULL_COUNT);
   assign wr_try_s    = (state_r == ST_FILL) && write_enable && !clear;
   assign wr_accept_s = wr_try_s && (!full_s || wrap_en);
   assign wr_drop_s   = wr_try_s && full_s && !wrap_en;
   assign start_s     = (state_r == ST_FILL) && rd_start && !clear;
   assign rd_issue_s  = (state_r == ST_READ) && rd_next && !clear && !inflight_r &&
                        (rd_cnt_r != count_r);
   // Finish once every word has been issued and the last one has left the RAM stage
   assign rd_finish_s = (state_r == ST_READ) && !inflight_r && (rd_cnt_r == count_r);

   // Next write pointer and fill count; the count saturates once full
   always_comb begin
      wr_ptr_nxt_s = wr_ptr_r;
      count_nxt_s  = count_r;
      if (wr_accept_s) begin
         wr_ptr_nxt_s = wr_ptr_r + 1'b1;
         if (!full_s) begin
            count_nxt_s = count_r + 1'b1;
         end else begin
            count_nxt_s = count_r;
         end
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
         count_nxt_s  = count_r;
      end
   end

   // Phase sequencing: fill, then read out, then hold until cleared
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_FILL: begin
            if (start_s) begin
               state_nxt_s = ST_READ;
            end else begin
               state_nxt_s = ST_FILL;
            end
         end
         ST_READ: begin
            if (rd_finish_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_READ;
            end
         end
         ST_DONE: state_nxt_s = ST_DONE;
         default: state_nxt_s = ST_FILL;
      endcase
   end

   // Control state, pointers, counters and sticky status
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_FILL;
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         rd_cnt_r   <= '0;
         overflow_r <= 1'b0;
         inflight_r <= 1'b0;
         rd_done_r  <= 1'b0;
         last_sn_r  <= 32'd0;
      end else if (clear) begin
         state_r    <= ST_FILL;
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         rd_cnt_r   <= '0;
         overflow_r <= 1'b0;
         inflight_r <= 1'b0;
         rd_done_r  <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         wr_ptr_r <= wr_ptr_nxt_s;
         count_r  <= count_nxt_s;
         if (wr_accept_s) begin
            last_sn_r <= sample_number;
         end
         if (wr_drop_s) begin
            overflow_r <= 1'b1;
         end
         // Oldest entry sits at the write pointer once the buffer has wrapped;
         // the next-cycle values include a write landing with rd_start.
         if (start_s) begin
            rd_ptr_r <= (count_nxt_s == FULL_COUNT) ? wr_ptr_nxt_s : '0;
            rd_cnt_r <= '0;
         end else if (rd_issue_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
            rd_cnt_r <= rd_cnt_r + 1'b1;
         end
         inflight_r <= rd_issue_s;
         if (rd_finish_s) begin
            rd_done_r <= 1'b1;
         end
      end
   end

   // Output register: take the RAM word the cycle after the read was issued
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data_r  <= '0;
         rd_valid_r <= 1'b0;
      end else if (clear) begin
         rd_valid_r <= 1'b0;
      end else begin
         rd_valid_r <= inflight_r;
         if (inflight_r) begin
            rd_data_r <= ram_q_s[SAMPLE_PACKET_WIDTH-1:0];
         end
      end
   end

`ifdef TRACE_BUFFER_PARITY_EN
   logic rd_parity_err_r;

   function automatic logic even_parity(input logic [SAMPLE_PACKET_WIDTH-1:0] d);
      return ^d;
   endfunction

   assign ram_wdata_s = {even_parity(samplePacket), samplePacket};

   // Parity check result, aligned with rd_valid
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_parity_err_r <= 1'b0;
      end else if (clear) begin
         rd_parity_err_r <= 1'b0;
      end else begin
         rd_parity_err_r <= inflight_r &&
            (even_parity(ram_q_s[SAMPLE_PACKET_WIDTH-1:0]) != ram_q_s[SAMPLE_PACKET_WIDTH]);
      end
   end

   assign rd_parity_err = rd_parity_err_r;
`else
   assign ram_wdata_s = samplePacket;
`endif

   trace_ram #(
      .DATA_WIDTH (RAM_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_accept_s),
      .wr_addr (wr_ptr_r),
      .wr_data (ram_wdata_s),
      .rd_en   (rd_issue_s),
      .rd_addr (rd_ptr_r),
      .rd_q    (ram_q_s)
   );

   assign pageFull           = full_s;
   assign overflow           = overflow_r;
   assign trace_size         = count_r;
   assign last_sample_number = last_sn_r;
   assign rd_data            = rd_data_r;
   assign rd_valid           = rd_valid_r;
   assign rd_done            = rd_done_r;

endmodule

// File: tb/tb_trace_buffer.sv
// tb_trace_buffer: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based model of the trace buffer.
module tb_trace_buffer;

   localparam int W     = 32;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          clear = 1'b0;
   logic          wrap_en = 1'b0;
   logic          write_enable = 1'b0;
   logic          rd_start = 1'b0;
   logic          rd_next = 1'b0;
   logic [W-1:0]  samplePacket = '0;
   logic [31:0]   sample_number = '0;
   logic          pageFull;
   logic          overflow;
   logic [AW:0]   trace_size;
   logic [31:0]   last_sample_number;
   logic [W-1:0]  rd_data;
   logic          rd_valid;
   logic          rd_done;
`ifdef TRACE_BUFFER_PARITY_EN
   logic          rd_parity_err;
`endif

   int checks = 0;
   int errors = 0;

   trace_buffer #(.SAMPLE_PACKET_WIDTH(W), .ADDR_WIDTH(AW)) dut (
      .clk                (clk),
      .reset              (reset),
      .clear              (clear),
      .wrap_en            (wrap_en),
      .samplePacket       (samplePacket),
      .write_enable       (write_enable),
      .sample_number      (sample_number),
      .pageFull           (pageFull),
      .overflow           (overflow),
      .trace_size         (trace_size),
      .last_sample_number (last_sample_number),
      .rd_start           (rd_start),
      .rd_next            (rd_next),
      .rd_data            (rd_data),
      .rd_valid           (rd_valid),
`ifdef TRACE_BUFFER_PARITY_EN
      .rd_parity_err      (rd_parity_err),
`endif
      .rd_done            (rd_done)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [W-1:0] m_q[$];       // stored entries, oldest first
   logic [W-1:0] m_snap[$];    // trace frozen at rd_start
   logic [W-1:0] got[$];       // words seen on rd_valid
   bit           m_reading = 1'b0;
   bit           m_finished = 1'b0;
   bit           m_pend = 1'b0;
   bit           m_was_pend = 1'b0;
   int           m_issued = 0;
   logic [W-1:0] m_pend_data = '0;
   logic         m_overflow = 1'b0;
   logic [31:0]  m_lsn = '0;
   logic [W-1:0] m_rd_data = '0;
   logic         m_rd_valid = 1'b0;
   logic         m_rd_done = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      if (!reset) begin
         m_q.delete();
         m_snap.delete();
         m_reading  = 1'b0;
         m_finished = 1'b0;
         m_pend     = 1'b0;
         m_issued   = 0;
         m_overflow = 1'b0;
         m_lsn      = '0;
         m_rd_data  = '0;
         m_rd_valid = 1'b0;
         m_rd_done  = 1'b0;
      end else if (clear) begin
         m_q.delete();
         m_reading  = 1'b0;
         m_finished = 1'b0;
         m_pend     = 1'b0;
         m_overflow = 1'b0;
         m_rd_valid = 1'b0;
         m_rd_done  = 1'b0;
      end else begin
         m_was_pend = m_pend;
         m_rd_valid = 1'b0;
         if (m_was_pend) begin
            m_rd_valid = 1'b1;
            m_rd_data  = m_pend_data;
            m_pend     = 1'b0;
         end
         if (!m_reading && !m_finished) begin
            if (write_enable) begin
               if (m_q.size() < DEPTH) begin
                  m_q.push_back(samplePacket);
                  m_lsn = sample_number;
               end else if (wrap_en) begin
                  void'(m_q.pop_front());
                  m_q.push_back(samplePacket);
                  m_lsn = sample_number;
               end else begin
                  m_overflow = 1'b1;
               end
            end
            if (rd_start) begin
               m_snap    = m_q;
               m_issued  = 0;
               m_reading = 1'b1;
            end
         end else if (m_reading) begin
            if (rd_next && !m_was_pend && m_issued < m_snap.size()) begin
               m_pend      = 1'b1;
               m_pend_data = m_snap[m_issued];
               m_issued++;
            end else if (!m_was_pend && m_issued == m_snap.size()) begin
               m_reading  = 1'b0;
               m_finished = 1'b1;
               m_rd_done  = 1'b1;
            end
         end
      end
   endtask

   task automatic compare();
      chk("trace_size", 64'(trace_size), 64'(m_q.size()));
      chk("pageFull", 64'(pageFull), 64'(m_q.size() == DEPTH));
      chk("overflow", 64'(overflow), 64'(m_overflow));
      chk("last_sample_number", 64'(last_sample_number), 64'(m_lsn));
      chk("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
      chk("rd_done", 64'(rd_done), 64'(m_rd_done));
      chk("rd_data", 64'(rd_data), 64'(m_rd_data));
`ifdef TRACE_BUFFER_PARITY_EN
      chk("rd_parity_err", 64'(rd_parity_err), 64'd0);
`endif
      if (rd_valid === 1'b1) got.push_back(rd_data);
   endtask

   initial forever begin
      @(posedge clk or negedge reset);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      compare();
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [W-1:0] d, input logic [31:0] sn);
      samplePacket  = d;
      sample_number = sn;
      write_enable  = 1'b1;
      tick();
      write_enable  = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      got.delete();
   endtask

   task automatic pulse_start();
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
   endtask

   // One rd_next per word; rd_valid must appear exactly two cycles later
   task automatic read_n(input int n);
      for (int i = 0; i < n; i++) begin
         rd_next = 1'b1;
         tick();
         chk("rd_latency_1", 64'(rd_valid), 64'd0);
         rd_next = 1'b0;
         tick();
         chk("rd_latency_2", 64'(rd_valid), 64'd1);
         tick();
      end
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (rd_done !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk(name, 64'(rd_done), 64'd1);
   endtask

   task automatic chk_got(input string name, input int n, input logic [W-1:0] base);
      chk({name, "_count"}, 64'(got.size()), 64'(n));
      for (int i = 0; i < n && i < got.size(); i++) begin
         chk(name, 64'(got[i]), 64'(base + W'(i)));
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      reset = 1'b0;
      repeat (3) tick();
      chk("rst_trace_size", 64'(trace_size), 64'd0);
      chk("rst_pageFull", 64'(pageFull), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("rst_rd_done", 64'(rd_done), 64'd0);
      chk("rst_rd_data", 64'(rd_data), 64'd0);
      reset = 1'b1;
      tick();

      // Basic fill and readout of five words
      for (int i = 0; i < 5; i++) do_write(32'hA0 + 32'(i), 32'd100 + 32'(i));
      chk("basic_trace_size", 64'(trace_size), 64'd5);
      chk("basic_lsn", 64'(last_sample_number), 64'd104);
      got.delete();
      pulse_start();
      read_n(5);
      wait_done("basic_done");
      chk_got("basic_data", 5, 32'hA0);
      chk("basic_size_after", 64'(trace_size), 64'd5);
      pulse_clear();

      // Circular capture keeps the most recent sixteen
      wrap_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         do_write(32'(i), 32'd500 + 32'(i));
         if (i == 14) chk("wrap_full_at_15", 64'(pageFull), 64'd0);
         if (i == 15) chk("wrap_full_at_16", 64'(pageFull), 64'd1);
      end
      chk("wrap_overflow", 64'(overflow), 64'd0);
      chk("wrap_trace_size", 64'(trace_size), 64'd16);
      pulse_start();
      read_n(16);
      wait_done("wrap_done");
      chk_got("wrap_data", 16, 32'd4);
      pulse_clear();

      // Stop-at-full drops the excess and flags overflow
      wrap_en = 1'b0;
      for (int i = 0; i < 18; i++) do_write(32'(i), 32'd1000 + 32'(i));
      chk("stop_pageFull", 64'(pageFull), 64'd1);
      chk("stop_overflow", 64'(overflow), 64'd1);
      chk("stop_lsn", 64'(last_sample_number), 64'd1015);
      pulse_start();
      read_n(16);
      wait_done("stop_done");
      chk_got("stop_data", 16, 32'd0);
      pulse_clear();
      chk("clear_overflow", 64'(overflow), 64'd0);

      // Back-to-back rd_next: only the first is honoured
      for (int i = 0; i < 3; i++) do_write(32'h30 + 32'(i), 32'(i));
      pulse_start();
      got.delete();
      rd_next = 1'b1;
      tick();
      tick();
      rd_next = 1'b0;
      repeat (4) tick();
      chk("b2b_one_valid", 64'(got.size()), 64'd1);
      pulse_clear();

      // clear beats an rd_next in the same cycle
      for (int i = 0; i < 3; i++) do_write(32'h40 + 32'(i), 32'(i));
      pulse_start();
      got.delete();
      rd_next = 1'b1;
      clear   = 1'b1;
      tick();
      rd_next = 1'b0;
      clear   = 1'b0;
      repeat (4) tick();
      chk("clr_no_valid", 64'(got.size()), 64'd0);
      chk("clr_trace_size", 64'(trace_size), 64'd0);
      do_write(32'h55, 32'd7);
      chk("clr_back_in_fill", 64'(trace_size), 64'd1);
      pulse_clear();

      // Write coinciding with rd_start is part of the trace
      do_write(32'h11, 32'd1);
      do_write(32'h12, 32'd2);
      samplePacket  = 32'h13;
      sample_number = 32'd3;
      write_enable  = 1'b1;
      rd_start      = 1'b1;
      tick();
      write_enable  = 1'b0;
      rd_start      = 1'b0;
      got.delete();
      read_n(3);
      wait_done("same_cycle_done");
      chk_got("same_cycle_data", 3, 32'h11);
      pulse_clear();

      // Asynchronous reset in the middle of a read
      for (int i = 0; i < 4; i++) do_write(32'h60 + 32'(i), 32'd70 + 32'(i));
      pulse_start();
      got.delete();
      rd_next = 1'b1;
      tick();
      rd_next = 1'b0;
      reset   = 1'b0;
      #1;
      chk("arst_trace_size", 64'(trace_size), 64'd0);
      chk("arst_lsn", 64'(last_sample_number), 64'd0);
      chk("arst_rd_data", 64'(rd_data), 64'd0);
      chk("arst_rd_done", 64'(rd_done), 64'd0);
      chk("arst_pageFull", 64'(pageFull), 64'd0);
      tick();
      chk("arst_no_valid", 64'(rd_valid), 64'd0);
      reset = 1'b1;
      tick();
      chk("arst_no_valid_count", 64'(got.size()), 64'd0);

      // Readout of an empty buffer completes at once
      pulse_start();
      wait_done("empty_done");
      chk("empty_no_valid", 64'(got.size()), 64'd0);
      pulse_clear();

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         samplePacket  = $urandom;
         sample_number = $urandom;
         write_enable  = ($urandom_range(0, 1) == 1);
         rd_next       = ($urandom_range(0, 2) == 0);
         rd_start      = ($urandom_range(0, 50) == 0);
         if (m_finished) clear = ($urandom_range(0, 4) == 0);
         else            clear = ($urandom_range(0, 300) == 0);
         if ($urandom_range(0, 80) == 0) wrap_en = ~wrap_en;
         tick();
      end
      write_enable = 1'b0;
      rd_next      = 1'b0;
      rd_start     = 1'b0;
      clear        = 1'b0;
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/trace_buffer.md
TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 SHALL have parameter SAMPLE_PACKET_WIDTH, default 32, width of one stored packet.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, log2 of buffer depth; DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port clear  input  1  sync pulse; empties buffer, returns to FILL.
REQ-006 SHALL have port wrap_en  input  1  1 = circular overwrite (pre-trigger), 0 = stop at full.
REQ-007 SHALL have port samplePacket  input  SAMPLE_PACKET_WIDTH  packet from capture engine.
REQ-008 SHALL have port write_enable  input  1  write strobe for samplePacket.
REQ-009 SHALL have port sample_number  input  32  sample index accompanying the packet.
REQ-010 SHALL have port pageFull  output  1  buffer holds DEPTH entries.
REQ-011 SHALL have port overflow  output  1  sticky; write dropped while full with wrap_en=0.
REQ-012 SHALL have port trace_size  output  ADDR_WIDTH+1  valid entries held.
REQ-013 SHALL have port last_sample_number  output  32  sample_number of last accepted write.
REQ-014 SHALL have port rd_start  input  1  pulse; freezes capture, enters READ.
REQ-015 SHALL have port rd_next  input  1  pulse; request next word, oldest first.
REQ-016 SHALL have port rd_data  output  SAMPLE_PACKET_WIDTH  readout word.
REQ-017 SHALL have port rd_valid  output  1  one-cycle pulse, rd_data valid.
REQ-018 SHALL have port rd_done  output  1  level; all trace_size words delivered.

Function
REQ-019 SHALL implement states FILL, READ, DONE; FILL->READ on rd_start; READ->DONE when read count reaches trace_size (immediately if trace_size=0); any state->FILL on clear.
REQ-020 In FILL, write_enable SHALL store samplePacket at wr_ptr, increment wr_ptr modulo DEPTH, latch last_sample_number.
REQ-021 trace_size SHALL increment per accepted write, saturating at DEPTH; pageFull = (trace_size == DEPTH), combinational from count.
REQ-022 Full with wrap_en=1: writes SHALL be accepted and overwrite oldest entry; trace_size stays DEPTH.
REQ-023 Full with wrap_en=0: writes SHALL be dropped and overflow set until clear or reset.
REQ-024 In READ/DONE, write_enable SHALL be ignored; overflow not set.
REQ-025 On rd_start, rd_ptr SHALL load oldest address: 0 if not full, else wr_ptr.
REQ-026 In READ, rd_next SHALL issue one RAM read; rd_valid pulses exactly 2 cycles after rd_next (1 RAM + 1 output register); rd_ptr increments modulo DEPTH.
REQ-027 rd_next while a read is in flight, or in FILL/DONE, SHALL be ignored.
REQ-028 Same-cycle write_enable and rd_start in FILL: write SHALL be accepted and included in the readout.
REQ-029 clear SHALL take priority over rd_start, rd_next and write_enable in the same cycle; in-flight read is discarded (no rd_valid).
REQ-030 rd_data SHALL hold its last value between rd_valid pulses.

Reset
REQ-031 reset low SHALL asynchronously force: state FILL, wr_ptr=0, rd_ptr=0, trace_size=0, overflow=0, last_sample_number=0, rd_data=0, rd_valid=0, rd_done=0, pageFull=0.
REQ-032 RAM contents SHALL not be reset; reset mid-read SHALL abort without rd_valid.

Configuration
REQ-033 Macro TRACE_BUFFER_PARITY_EN defined: each word SHALL store an even-parity bit; added output rd_parity_err pulses with rd_valid on mismatch.
REQ-034 Macro undefined: no parity storage; rd_parity_err SHALL be absent.

Structure
REQ-035 Package trace_pkg SHALL hold state encoding typedef and default width/depth constants.
REQ-036 Storage SHALL be sub-module trace_ram: simple dual-port, one write port, registered read port, 1-cycle latency.

Verification (ADDR_WIDTH=4, DEPTH=16)
REQ-037 5 writes 0xA0..0xA4, rd_start, 5 rd_next -> rd_data A0..A4, each 2 cycles after rd_next; rd_done after 5th; trace_size=5.
REQ-038 wrap_en=1, 20 writes 0..19 -> pageFull=1 from 16th write; readout 4..19; overflow=0.
REQ-039 wrap_en=0, 18 writes -> pageFull=1, overflow=1, readout 0..15, last_sample_number = sample_number of 16th write.
REQ-040 rd_next on consecutive cycles -> second ignored; only one rd_valid.
REQ-041 clear same cycle as rd_next in READ -> no rd_valid; state FILL; trace_size=0.
REQ-042 reset low mid-READ -> all REQ-031 values next cycle; rd_start with empty buffer -> rd_done=1, no rd_valid.
